// File: rtl/dram_arb_pkg.sv
// Shared encodings and default widths for the two-port DRAM command arbiter.
package dram_arb_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_REFRESH = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_REFRESH = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag and an
// overrun flag raised when a new interval expires before the last refresh ran.
module dram_refresh_timer #(
  parameter int REFRESH_CYCLES = 390
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_pending,
  output logic refresh_pending,
  output logic refresh_overrun
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             hit;

  always_comb begin
    hit       = (count_q == '0);
    count_d   = hit ? RELOAD : count_q - CNT_W'(1);
    // A new expiry wins over a same-cycle clear so no interval is lost.
    pending_d = hit | (pending_q & ~clr_pending);
    overrun_d = overrun_q | (hit & pending_q & ~clr_pending);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign refresh_pending = pending_q;
  assign refresh_overrun = overrun_q;

endmodule

// File: rtl/dram_arbiter.sv
// Two-port DRAM command arbiter with refresh priority and round-robin port
// selection; define DRAM_ARB_FIXED_PRIO_EN to make port A always win ties.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int REFRESH_CYCLES = 390
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [1:0]        mem_cmd_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              refresh_overrun
);

  arb_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic              owner_b_q, owner_b_d;
  logic              last_b_q, last_b_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              refresh_pending;
  logic              refresh_clr;
  logic              pick_b;

  dram_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .clr_pending    (refresh_clr),
    .refresh_pending(refresh_pending),
    .refresh_overrun(refresh_overrun)
  );

  assign refresh_clr = (state_q == ST_REFRESH) && mem_cmd_ready;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  assign pick_b = b_req && !a_req;
`else
  // On a tie the port that was not selected last time wins.
  assign pick_b = b_req && (!a_req || !last_b_q);
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    owner_b_d = owner_b_q;
    last_b_d  = last_b_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (refresh_pending) begin
          op_d    = OP_REFRESH;
          state_d = ST_REFRESH;
        end else if (a_req || b_req) begin
          owner_b_d = pick_b;
          last_b_d  = pick_b;
          op_d      = (pick_b ? b_we : a_we) ? OP_WRITE : OP_READ;
          addr_d    = pick_b ? b_addr : a_addr;
          wdata_d   = pick_b ? b_wdata : a_wdata;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_cmd_ready) state_d = (op_q == OP_WRITE) ? ST_IDLE : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (mem_rvalid) begin
          if (owner_b_q) b_rdata_d = mem_rdata;
          else           a_rdata_d = mem_rdata;
          state_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        if (mem_cmd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      owner_b_q <= owner_b_d;
      last_b_q  <= last_b_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign mem_cmd_valid = (state_q == ST_ISSUE) || (state_q == ST_REFRESH);
  assign mem_cmd_op    = op_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

  assign a_gnt    = (state_q == ST_ISSUE) && mem_cmd_ready && !owner_b_q;
  assign b_gnt    = (state_q == ST_ISSUE) && mem_cmd_ready &&  owner_b_q;

  // Read data is forwarded in the return cycle and held afterwards.
  assign a_rvalid = (state_q == ST_WAIT_RD) && mem_rvalid && !owner_b_q;
  assign b_rvalid = (state_q == ST_WAIT_RD) && mem_rvalid &&  owner_b_q;
  assign a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
  assign b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a default-parameter instance plus a
// short-refresh instance sharing the same stimulus.
module tb_dram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          mem_cmd_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_cmd_valid, refresh_overrun;
  logic [1:0]    mem_cmd_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  logic          r_a_gnt, r_a_rvalid, r_b_gnt, r_b_rvalid;
  logic [DW-1:0] r_a_rdata, r_b_rdata;
  logic          r_mem_cmd_valid, r_refresh_overrun;
  logic [1:0]    r_mem_cmd_op;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  int checks = 0;
  int failures = 0;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_CYCLES(390)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_op(mem_cmd_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .refresh_overrun(refresh_overrun)
  );

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_CYCLES(16)) dut_r (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(r_a_gnt), .a_rvalid(r_a_rvalid), .a_rdata(r_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(r_b_gnt), .b_rvalid(r_b_rvalid), .b_rdata(r_b_rdata),
    .mem_cmd_valid(r_mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_op(r_mem_cmd_op), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .refresh_overrun(r_refresh_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    mem_cmd_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    step();
    step();
    reset_n = 1;
  endtask

  task automatic wait_gnt(output logic ga, output logic gb);
    int k;
    k = 0;
    while (!(a_gnt || b_gnt) && k < 20) begin
      step();
      k++;
    end
    ga = a_gnt;
    gb = b_gnt;
    if (!(ga || gb)) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ga, gb, spur, bad;
    logic [3:0] exp_b;
    int         rf[$];
    int         gcount;

    // Reset state with live-looking inputs
    idle_inputs();
    reset_n = 0;
    a_req = 1; a_we = 1; a_addr = 24'h000777; mem_cmd_ready = 1;
    mem_rvalid = 1; mem_rdata = 16'hFFFF;
    step(); step();
    check("rst_valid", mem_cmd_valid, 0);
    check("rst_op", mem_cmd_op, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_gnt", {a_gnt, b_gnt}, 0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    check("rst_ovr", refresh_overrun, 0);

    // Single write from A
    do_reset();
    mem_cmd_ready = 1;
    a_req = 1; a_we = 1; a_addr = 24'h000123; a_wdata = 16'hBEEF;
    #1;
    check("wr_idle_valid", mem_cmd_valid, 0);
    step();
    check("wr_valid", mem_cmd_valid, 1);
    check("wr_op", mem_cmd_op, 1);
    check("wr_addr", mem_addr, 24'h000123);
    check("wr_wdata", mem_wdata, 16'hBEEF);
    check("wr_gnt", {a_gnt, b_gnt}, 2'b10);
    a_req = 0;
    step();
    check("wr_done_valid", mem_cmd_valid, 0);
    check("wr_done_gnt", a_gnt, 0);

    // Four simultaneous reads: grant order
`ifdef DRAM_ARB_FIXED_PRIO_EN
    exp_b = 4'b0000;
`else
    exp_b = 4'b0101;
`endif
    do_reset();
    mem_cmd_ready = 1;
    a_req = 1; b_req = 1; a_addr = 24'h000111; b_addr = 24'h000222;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(ga, gb);
      check("rr_order", gb, exp_b[i]);
      check("rr_addr", mem_addr, gb ? 24'h000222 : 24'h000111);
      step();
      mem_rvalid = 1;
      mem_rdata = 16'h1000 + 16'(i);
      #1;
      check("rr_rvalid", gb ? b_rvalid : a_rvalid, 1);
      check("rr_rvalid_other", gb ? a_rvalid : b_rvalid, 0);
      check("rr_rdata", gb ? b_rdata : a_rdata, 16'h1000 + 16'(i));
      step();
      mem_rvalid = 0;
    end

    // Read by B with late return
    do_reset();
    mem_cmd_ready = 1;
    b_req = 1; b_addr = 24'h0ABCDE;
    step();
    check("rdb_gnt", {a_gnt, b_gnt}, 2'b01);
    check("rdb_op", mem_cmd_op, 0);
    check("rdb_addr", mem_addr, 24'h0ABCDE);
    b_req = 0;
    step();
    spur = 0;
    for (int k = 0; k < 4; k++) begin
      spur = spur | a_rvalid | b_rvalid;
      step();
    end
    check("rdb_spurious", spur, 0);
    mem_rvalid = 1; mem_rdata = 16'h5A5A;
    #1;
    check("rdb_rvalid", {a_rvalid, b_rvalid}, 2'b01);
    check("rdb_rdata", b_rdata, 16'h5A5A);
    step();
    mem_rvalid = 0; mem_rdata = 16'h0000;
    #1;
    check("rdb_pulse_end", b_rvalid, 0);
    check("rdb_hold", b_rdata, 16'h5A5A);
    check("rdb_a_rdata", a_rdata, 0);

    // Backpressure: command held stable, requester withdraws early
    do_reset();
    a_req = 1; a_we = 1; a_addr = 24'hABCDEF; a_wdata = 16'h1234;
    step();
    a_req = 0; a_addr = '0; a_wdata = '0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      bad = bad | (mem_cmd_valid !== 1'b1) | (mem_addr !== 24'hABCDEF) |
            (mem_wdata !== 16'h1234) | (mem_cmd_op !== 2'd1) | a_gnt | b_gnt;
      step();
    end
    check("stall_stable", bad, 0);
    mem_cmd_ready = 1;
    #1;
    check("stall_gnt", a_gnt, 1);
    check("stall_addr", mem_addr, 24'hABCDEF);
    step();
    check("stall_done", {mem_cmd_valid, a_gnt}, 0);

    // Refresh every 16 cycles ahead of a busy port A, then overrun
    do_reset();
    mem_cmd_ready = 1;
    a_req = 1; a_we = 1; a_addr = 24'h000055;
    gcount = 0;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (r_mem_cmd_valid && r_mem_cmd_op == 2'd2 && mem_cmd_ready) rf.push_back(c);
      if (r_a_gnt) gcount++;
    end
    check("ref_count", rf.size(), 2);
    check("ref_first", (rf.size() > 0) ? rf[0] : 0, 17);
    check("ref_gap", (rf.size() > 1) ? rf[1] - rf[0] : 0, 16);
    check("ref_a_gnts", gcount, 22);
    check("ovr_before", r_refresh_overrun, 0);
    mem_cmd_ready = 0;
    for (int k = 0; k < 20; k++) step();
    check("ovr_set", r_refresh_overrun, 1);
    check("ovr_ref_held", {r_mem_cmd_valid, r_mem_cmd_op}, 3'b110);
    check("ovr_no_gnt", r_a_gnt, 0);
    mem_cmd_ready = 1;
    step(); step();
    check("ovr_sticky", r_refresh_overrun, 1);

    // Reset during WAIT_RD aborts the read
    do_reset();
    mem_cmd_ready = 1;
    a_req = 1; a_addr = 24'h000042;
    step();
    a_req = 0;
    step();
    mem_rvalid = 1; mem_rdata = 16'h7777;
    #1;
    check("ab_first_rdata", a_rdata, 16'h7777);
    step();
    mem_rvalid = 0;
    a_req = 1;
    step();
    a_req = 0;
    step();
    reset_n = 0;
    #1;
    check("ab_valid", mem_cmd_valid, 0);
    check("ab_addr", mem_addr, 0);
    check("ab_rdata", a_rdata, 0);
    check("ab_rvalid", {a_rvalid, b_rvalid, a_gnt}, 0);
    step();
    reset_n = 1;
    step(); step();
    mem_rvalid = 1; mem_rdata = 16'h9999;
    #1;
    check("ab_late_rvalid", {a_rvalid, b_rvalid}, 0);
    check("ab_late_rdata", a_rdata, 0);
    mem_rvalid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
